// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types and constants for the RGB fade sequencer: state encoding,
// level width, preset count, default preset table and the gamma helper.
package rgb_pkg;

  localparam int unsigned LVL_W   = 8;
  localparam int unsigned NPRESET = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef logic [LVL_W-1:0] lvl_t;
  // Channel 0 = R, 1 = G, 2 = B.
  typedef lvl_t [2:0] rgb_t;

  localparam rgb_t P0_DEF = {8'd0,   8'd0,   8'd255};
  localparam rgb_t P1_DEF = {8'd0,   8'd255, 8'd0  };
  localparam rgb_t P2_DEF = {8'd255, 8'd0,   8'd0  };
  localparam rgb_t P3_DEF = {8'd255, 8'd255, 8'd255};

  localparam rgb_t [NPRESET-1:0] PRESET_DEF = {P3_DEF, P2_DEF, P1_DEF, P0_DEF};

  // Square-law perceptual mapping: (l*l) >> 8.
  function automatic lvl_t gamma_map(input lvl_t l);
    logic [2*LVL_W-1:0] sq;
    sq = {{LVL_W{1'b0}}, l} * {{LVL_W{1'b0}}, l};
    return sq[2*LVL_W-1:LVL_W];
  endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Bus bundle between the encoder front end / config host and the fade
// sequencer. The sequencer uses the slave modport.
interface rgb_fade_sequencer_if;
  import rgb_pkg::*;

  logic       mode_auto;
  lvl_t       man_level0;
  lvl_t       man_level1;
  lvl_t       man_level2;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [1:0] cfg_chan;
  lvl_t       cfg_data;
  lvl_t       level0;
  lvl_t       level1;
  lvl_t       level2;
  logic       level_upd;
  logic [1:0] state;
  logic [1:0] preset_idx;

  modport master (
    output mode_auto, man_level0, man_level1, man_level2,
    output cfg_we, cfg_addr, cfg_chan, cfg_data,
    input  level0, level1, level2, level_upd, state, preset_idx
  );

  modport slave (
    input  mode_auto, man_level0, man_level1, man_level2,
    input  cfg_we, cfg_addr, cfg_chan, cfg_data,
    output level0, level1, level2, level_upd, state, preset_idx
  );

endinterface

// File: rtl/rgb_fade_step.sv
// One-channel fade step: moves a level at most STEP LSBs toward its target
// using 9-bit arithmetic so the result never overshoots or wraps.
// o_at_target reports whether the stepped value equals the target.
module rgb_fade_step
  import rgb_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  lvl_t i_level,
  input  lvl_t i_target,
  output lvl_t o_next,
  output logic o_at_target
);

  logic [LVL_W:0] w_cur;
  logic [LVL_W:0] w_tgt;
  logic [LVL_W:0] w_step;
  logic [LVL_W:0] w_dist;

  assign w_cur  = {1'b0, i_level};
  assign w_tgt  = {1'b0, i_target};
  assign w_step = (LVL_W+1)'(STEP);

  // Snap to target when within STEP, otherwise move STEP toward it.
  always_comb begin
    o_next = i_level;
    if (w_tgt >= w_cur) begin
      w_dist = w_tgt - w_cur;
      o_next = (w_dist <= w_step) ? i_target : lvl_t'(w_cur + w_step);
    end else begin
      w_dist = w_cur - w_tgt;
      o_next = (w_dist <= w_step) ? i_target : lvl_t'(w_cur - w_step);
    end
  end

  assign o_at_target = (o_next == i_target);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: manual pass-through of encoder levels, or automatic
// fade/hold cycling through a writable 4-entry preset table.
// Optional macro GAMMA_EN adds a registered square-law output stage.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rgb_fade_sequencer_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  state_t                 r_state;
  logic [PW-1:0]          r_presc;
  logic [HW-1:0]          r_hold;
  logic [1:0]             r_idx;
  rgb_t                   r_level;
  rgb_t [NPRESET-1:0]     r_table;
  logic                   r_upd;

  rgb_t                   w_man;
  rgb_t                   w_target;
  rgb_t                   w_next;
  logic [2:0]             w_at;
  logic                   w_tick;
  rgb_t                   w_level_nxt;
  rgb_t                   w_out;

  assign w_man    = {bus.man_level2, bus.man_level1, bus.man_level0};
  assign w_target = r_table[r_idx];
  assign w_tick   = (r_state != ST_IDLE) && (r_presc == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < 3; g++) begin : g_ch
    rgb_fade_step #(.STEP(STEP)) u_step (
      .i_level     (r_level[g]),
      .i_target    (w_target[g]),
      .o_next      (w_next[g]),
      .o_at_target (w_at[g])
    );
  end

  // Preset table: reloads defaults on reset, single-entry writes otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_table <= PRESET_DEF;
    end else if (bus.cfg_we && (bus.cfg_chan != 2'd3)) begin
      r_table[bus.cfg_addr][bus.cfg_chan] <= bus.cfg_data;
    end
  end

  // Next internal level; shared by the FSM and the change detector.
  always_comb begin
    w_level_nxt = r_level;
    case (r_state)
      ST_IDLE: if (!bus.mode_auto) w_level_nxt = w_man;
      ST_FADE: if (bus.mode_auto && w_tick) w_level_nxt = w_next;
      default: ;
    endcase
  end

  // Sequencer FSM with prescaler and hold counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_hold  <= '0;
      r_idx   <= '0;
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_presc <= (r_state == ST_IDLE || w_tick) ? '0 : r_presc + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.mode_auto) begin
            r_state <= ST_FADE;
            r_presc <= '0;
          end
        end
        ST_FADE: begin
          if (!bus.mode_auto) begin
            r_state <= ST_IDLE;
          end else if (w_tick && (&w_at)) begin
            r_state <= ST_HOLD;
            r_hold  <= HW'(HOLD_TICKS);
          end
        end
        ST_HOLD: begin
          if (!bus.mode_auto) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_hold <= r_hold - 1'b1;
            if (r_hold == HW'(1)) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_FADE;
              r_presc <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GAMMA_EN
  rgb_t w_gam_nxt;
  rgb_t r_gam;

  // Gamma of the current internal levels.
  always_comb begin
    w_gam_nxt = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_gam_nxt[i] = gamma_map(r_level[i]);
    end
  end

  // Output stage; the change pulse follows the gamma value so equal-mapped
  // level steps stay silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gam <= '0;
      r_upd <= 1'b0;
    end else begin
      r_gam <= w_gam_nxt;
      r_upd <= (w_gam_nxt != r_gam);
    end
  end

  assign w_out = r_gam;
`else
  // Change pulse, registered alongside the level update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upd <= 1'b0;
    end else begin
      r_upd <= (w_level_nxt != r_level);
    end
  end

  assign w_out = r_level;
`endif

  assign bus.level0     = w_out[0];
  assign bus.level1     = w_out[1];
  assign bus.level2     = w_out[2];
  assign bus.level_upd  = r_upd;
  assign bus.state      = r_state;
  assign bus.preset_idx = r_idx;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer (TICK_DIV=4, STEP=64, HOLD_TICKS=2).
// Manual-mode table vectors plus hand-built fade/hold/retarget/reset/wrap
// sequences. Expectations follow GAMMA_EN when the macro is defined.
module tb_rgb_fade_sequencer;

`ifdef GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rgb_fade_sequencer_if u_if ();

  rgb_fade_sequencer #(
    .TICK_DIV   (4),
    .STEP       (64),
    .HOLD_TICKS (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    logic [7:0] m0, m1, m2;
    logic       exp_upd;
  } mvec_t;

  typedef struct {
    logic [7:0] e0, e1, e2;
    logic [1:0] st;
  } fvec_t;

  function automatic logic [7:0] g(input logic [7:0] x);
    logic [15:0] sq;
    sq = {8'd0, x} * {8'd0, x};
    return sq[15:8];
  endfunction

  function automatic logic [7:0] eo(input logic [7:0] x);
`ifdef GAMMA_EN
    return g(x);
`else
    return x;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_lv(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
    chk({name, ".r"}, u_if.level0, eo(a));
    chk({name, ".g"}, u_if.level1, eo(b));
    chk({name, ".b"}, u_if.level2, eo(c));
  endtask

  mvec_t mv[6];
  fvec_t fv[4];

  initial begin
    logic [7:0] p0, p1, p2;
    logic       eu;

    mv[0] = '{8'd10,  8'd20,  8'd30, 1'b1};
    mv[1] = '{8'd10,  8'd20,  8'd30, 1'b0};
    mv[2] = '{8'd255, 8'd128, 8'd0,  1'b1};
    mv[3] = '{8'd1,   8'd1,   8'd1,  1'b1};
    mv[4] = '{8'd0,   8'd0,   8'd0,  1'b1};
    mv[5] = '{8'd0,   8'd0,   8'd0,  1'b0};

    fv[0] = '{8'd64,  8'd0, 8'd0, 2'd1};
    fv[1] = '{8'd128, 8'd0, 8'd0, 2'd1};
    fv[2] = '{8'd192, 8'd0, 8'd0, 2'd1};
    fv[3] = '{8'd255, 8'd0, 8'd0, 2'd2};

    u_if.mode_auto  = 1'b0;
    u_if.man_level0 = '0;
    u_if.man_level1 = '0;
    u_if.man_level2 = '0;
    u_if.cfg_we     = 1'b0;
    u_if.cfg_addr   = '0;
    u_if.cfg_chan   = '0;
    u_if.cfg_data   = '0;

    // Reset state
    cyc(2);
    chk_lv("rst", 8'd0, 8'd0, 8'd0);
    chk("rst.upd", u_if.level_upd, 0);
    chk("rst.state", u_if.state, 0);
    chk("rst.idx", u_if.preset_idx, 0);
    rst_n = 1'b1;

    // Manual pass-through vectors
    p0 = 8'd0; p1 = 8'd0; p2 = 8'd0;
    for (int i = 0; i < 6; i++) begin
      u_if.man_level0 = mv[i].m0;
      u_if.man_level1 = mv[i].m1;
      u_if.man_level2 = mv[i].m2;
      cyc(LAT);
      eu = mv[i].exp_upd;
`ifdef GAMMA_EN
      eu = (g(mv[i].m0) != g(p0)) || (g(mv[i].m1) != g(p1)) || (g(mv[i].m2) != g(p2));
`endif
      chk_lv($sformatf("man%0d", i), mv[i].m0, mv[i].m1, mv[i].m2);
      chk($sformatf("man%0d.upd", i), u_if.level_upd, eu);
      chk($sformatf("man%0d.state", i), u_if.state, 0);
      p0 = mv[i].m0; p1 = mv[i].m1; p2 = mv[i].m2;
    end

    // Auto fade from 0 toward P0, one check per tick
    u_if.mode_auto = 1'b1;
    cyc(LAT);
    for (int k = 0; k < 4; k++) begin
      cyc(4);
      chk_lv($sformatf("fade%0d", k), fv[k].e0, fv[k].e1, fv[k].e2);
      chk($sformatf("fade%0d.state", k), u_if.state, fv[k].st);
    end

    // Two hold ticks then advance to P1
    cyc(8);
    chk("hold.idx", u_if.preset_idx, 1);
    chk("hold.state", u_if.state, 1);
    cyc(4);
    chk_lv("p1t1", 8'd191, 8'd64, 8'd0);

    // Retarget active preset mid-fade: P1.G = 7
    u_if.cfg_we = 1'b1; u_if.cfg_addr = 2'd1; u_if.cfg_chan = 2'd1; u_if.cfg_data = 8'd7;
    cyc(1);
    u_if.cfg_we = 1'b0;
    cyc(3);
    chk_lv("retgt", 8'd127, 8'd7, 8'd0);

    // One-cycle reset mid-fade
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk_lv("rst2", 8'd0, 8'd0, 8'd0);
    chk("rst2.state", u_if.state, 0);
    chk("rst2.idx", u_if.preset_idx, 0);
    chk("rst2.upd", u_if.level_upd, 0);

    // Refade P0, hold, first P1 tick shows restored default G = 255 target
    cyc(28 + LAT);
    chk_lv("p1rest", 8'd191, 8'd64, 8'd0);
    chk("p1rest.idx", u_if.preset_idx, 1);

    // Run through P1, P2, P3 and wrap to P0
    cyc(68);
    chk("wrap.idx", u_if.preset_idx, 0);
    chk("wrap.state", u_if.state, 1);
    cyc(4);
    chk_lv("wrapt1", 8'd255, 8'd191, 8'd191);

    // Leave auto mid-fade: level held one edge, then manual tracking
    u_if.mode_auto = 1'b0;
    u_if.man_level0 = 8'd9; u_if.man_level1 = 8'd9; u_if.man_level2 = 8'd9;
    cyc(1);
    chk("exit.state", u_if.state, 0);
    chk_lv("exit.hold", 8'd255, 8'd191, 8'd191);
    cyc(LAT);
    chk_lv("exit.man", 8'd9, 8'd9, 8'd9);

    // Target equal to current levels still costs one tick
    u_if.man_level0 = 8'd255; u_if.man_level1 = 8'd0; u_if.man_level2 = 8'd0;
    cyc(LAT);
    chk_lv("eq.pre", 8'd255, 8'd0, 8'd0);
    u_if.mode_auto = 1'b1;
    cyc(4);
    chk("eq.fade", u_if.state, 1);
    cyc(1);
    chk("eq.hold", u_if.state, 2);
    chk("eq.upd", u_if.level_upd, 0);
    chk("eq.idx", u_if.preset_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
